memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of execute_stage. Consumes the EX/MEM register contents: ALU result, store data, PC, flags, mem control.
//  Owns the 16-bit data memory and the stack pointer (SP). Performs load, store, PUSH/POP, two-word PC push (CALL/INT) and PC pop (RET/RTI).
//  Registers results into the MEM/WB boundary and returns popped PC/flags to fetch and execute.
// PARAMETERS
//  ADDR_WIDTH  12                   data memory address width (2^12 words)
//  DATA_WIDTH  16                   memory word / register width
//  SP_RESET    (1<<ADDR_WIDTH)-1    SP value after reset (empty stack, top of memory)
// PORTS
//  clk                         in   1   rising-edge clock
//  reset                       in   1   asynchronous, active-high
//  mem_read                    in   1   load / pop request
//  mem_write                   in   1   store / push request
//  mem_push                    in   1   stack push: SP-based, decrement SP
//  mem_pop                     in   1   stack pop: SP-based, increment SP
//  reg_write                   in   1   write-back enable from EX/MEM
//  wb_sel                      in   2   write-back source select, passed through
//  memory_address_select       in   2   00 ALU result, 01 SP (push), 10 SP+1 (pop), 11 reserved (no access)
//  memory_write_src_select     in   2   00 store_data, 01 PC (2 words), 10 {flags,PC} (2 words), 11 reserved (no write)
//  alu_result                  in   16  ALU output / effective address
//  store_data                  in   16  register data for STD/PUSH
//  PC                          in   32  return PC for CALL/INT
//  flags                       in   3   condition code register for INT
//  mem_data_out                out  16  registered read data to MEM/WB
//  alu_result_out              out  16  registered alu_result to MEM/WB
//  reg_write_out               out  1   registered write-back enable
//  wb_sel_out                  out  2   registered wb_sel
//  stall                       out  1   hold EX/MEM and upstream stages this cycle
//  pc_from_mem                 out  32  popped PC
//  pc_load                     out  1   one-cycle pulse: pc_from_mem valid
//  conditions_from_memory_pop  out  3   popped flags (RTI)
//  flags_load                  out  1   one-cycle pulse: conditions_from_memory_pop valid
//  empty_stack_exception       out  1   one-cycle pulse: pop attempted on empty stack
// BEHAVIOUR
//  Reset values:
//   - SP=SP_RESET, FSM=IDLE; all outputs 0. Memory contents are not cleared.
//   - Reset mid two-word op aborts it: no second write, SP=SP_RESET.
//  Memory: asynchronous array read; write on rising edge; read data is registered, so mem_data_out is valid 1 cycle after the request.
//   - mem_read and mem_write in the same cycle: write performed; mem_data_out gets the pre-write word (read-before-write).
//  Single-word ops (write_src 00, or read with addr_sel 00/10):
//   - Store: M[alu_result]<=store_data.
//   - PUSH: M[SP]<=store_data, then SP<=SP-1.
//   - POP: mem_data_out<=M[SP+1], SP<=SP+1.
//  Two-word FSM, states IDLE -> SECOND -> IDLE:
//   - Push, write_src 01/10: the IDLE cycle writes M[SP]<=high word and asserts stall.
//     SECOND writes M[SP-1]<=PC[15:0], sets SP<=SP-2 and deasserts stall.
//     High word is PC[31:16] for 01, {flags,PC[28:16]} for 10. PC[31:29] is not preserved on INT.
//   - Pop, mem_pop & mem_read with pc-pop decode (write_src 01/10): the IDLE cycle latches M[SP+1] as the low word and asserts stall.
//     SECOND reads M[SP+2] and sets SP<=SP+2. On the following edge pc_from_mem and pc_load=1 are registered.
//     For 10: pc_from_mem={3'b0,hi[12:0],lo}, conditions_from_memory_pop=hi[15:13], flags_load=1.
//  Stall: stall is combinational, high only in the IDLE cycle of a two-word op. reg_write_out is forced 0 for the stalled cycle.
//  Empty stack: pop with SP==SP_RESET (or SP==SP_RESET-1 for a two-word pop) gives empty_stack_exception=1 for 1 cycle.
//   - No SP change, no read, no stall, reg_write_out=0.
//  SP arithmetic is modulo 2^ADDR_WIDTH; push at SP=0 wraps to SP_RESET, with no exception.
//  pc_load, flags_load and empty_stack_exception are single-cycle pulses.
//  Pass-through regs (alu_result_out, wb_sel_out, reg_write_out) update every non-stalled cycle.
// TESTING
//  1. reset=1 mid-SECOND of a CALL push -> outputs 0, SP=4095, M[4094] unchanged after release.
//  2. Store 0xBEEF at alu_result=0x010, then load 0x010 -> mem_data_out=0xBEEF one cycle after the load.
//  3. PUSH 0x1234 from SP=4095, then POP -> SP 4094 then 4095; mem_data_out=0x1234; no stall.
//  4. CALL with PC=0x0001_0020 from SP=4095 -> stall=1 for 1 cycle; M[4095]=0x0001, M[4094]=0x0020, SP=4093.
//     RET then gives pc_load pulse with pc_from_mem=0x0001_0020 and SP=4095.
//  5. INT with flags=3'b101, PC=0x0000_0040, then RTI -> conditions_from_memory_pop=3'b101, flags_load=1, pc_from_mem=0x40.
//  6. POP at SP=4095 -> empty_stack_exception 1-cycle pulse, SP stays 4095, reg_write_out=0.

Source files
------------

// File: rtl/memory_stage_if.sv
// memory_stage_if: EX/MEM request bundle and MEM/WB result bundle.
// master is the upstream side, slave is the memory stage.
interface memory_stage_if;
    logic        mem_read;
    logic        mem_write;
    logic        mem_push;
    logic        mem_pop;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [1:0]  memory_address_select;
    logic [1:0]  memory_write_src_select;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [31:0] PC;
    logic [2:0]  flags;

    logic [15:0] mem_data_out;
    logic [15:0] alu_result_out;
    logic        reg_write_out;
    logic [1:0]  wb_sel_out;
    logic        stall;
    logic [31:0] pc_from_mem;
    logic        pc_load;
    logic [2:0]  conditions_from_memory_pop;
    logic        flags_load;
    logic        empty_stack_exception;

    modport master (
        output mem_read, mem_write, mem_push, mem_pop,
        output reg_write, wb_sel,
        output memory_address_select, memory_write_src_select,
        output alu_result, store_data, PC, flags,
        input  mem_data_out, alu_result_out, reg_write_out,
        input  wb_sel_out, stall, pc_from_mem, pc_load,
        input  conditions_from_memory_pop, flags_load,
        input  empty_stack_exception
    );

    modport slave (
        input  mem_read, mem_write, mem_push, mem_pop,
        input  reg_write, wb_sel,
        input  memory_address_select, memory_write_src_select,
        input  alu_result, store_data, PC, flags,
        output mem_data_out, alu_result_out, reg_write_out,
        output wb_sel_out, stall, pc_from_mem, pc_load,
        output conditions_from_memory_pop, flags_load,
        output empty_stack_exception
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: data memory, stack pointer and MEM/WB register.
// Two-word PC push/pop runs over IDLE -> SECOND with a one-cycle stall.
module memory_stage #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] SP_RESET = {ADDR_WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    memory_stage_if.slave bus
);
    typedef enum logic {IDLE, SECOND} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] SP_LAST = SP_RESET - ONE;

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] sp_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  op_pop_q;
    logic                  kind_q;

    logic [15:0] mdo_q;
    logic [15:0] alu_q;
    logic        rw_q;
    logic [1:0]  wb_q;
    logic [31:0] pc_q;
    logic        pcl_q;
    logic [2:0]  cond_q;
    logic        fll_q;
    logic        exc_q;

    logic                  wsrc00;
    logic                  pc_src;
    logic                  pop_req;
    logic                  two_pop;
    logic                  two_push;
    logic                  one_push;
    logic                  one_pop;
    logic                  idle;
    logic                  empty;
    logic                  exc_c;
    logic                  stall_c;
    logic                  rd_en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] sp_p1;
    logic [ADDR_WIDTH-1:0] sp_p2;
    logic [ADDR_WIDTH-1:0] sp_m1;
    logic [ADDR_WIDTH-1:0] sp_m2;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] hi_w;
    logic [DATA_WIDTH-1:0] pop_hi;

    // Decode the request against the current stack state
    always_comb begin
        sp_p1 = sp_q + ONE;
        sp_p2 = sp_q + TWO;
        sp_m1 = sp_q - ONE;
        sp_m2 = sp_q - TWO;
        wsrc00 = (bus.memory_write_src_select == 2'b00);
        pc_src = (bus.memory_write_src_select == 2'b01)
               | (bus.memory_write_src_select == 2'b10);
        pop_req  = bus.mem_pop & bus.mem_read;
        two_pop  = pop_req & pc_src;
        two_push = bus.mem_push & bus.mem_write & pc_src;
        one_push = bus.mem_push & bus.mem_write & wsrc00;
        one_pop  = pop_req & ~pc_src;
        idle  = (state_q == IDLE);
        empty = pop_req & ((sp_q == SP_RESET)
              | (two_pop & (sp_q == SP_LAST)));
        exc_c   = idle & empty;
        stall_c = ~reset & idle & ~empty & (two_push | two_pop);
        rd_en   = bus.mem_read & (bus.memory_address_select != 2'b11);
        if (bus.memory_write_src_select == 2'b01)
            hi_w = bus.PC[31:16];
        else
            hi_w = {bus.flags, bus.PC[28:16]};
        pop_hi = mem_q[sp_p2];
        unique case (bus.memory_address_select)
            2'b00:   addr = bus.alu_result[ADDR_WIDTH-1:0];
            2'b01:   addr = sp_q;
            2'b10:   addr = sp_p1;
            default: addr = sp_q;
        endcase
    end

    // Pick the single memory write for this cycle
    always_comb begin
        we    = 1'b0;
        waddr = addr;
        wdata = bus.store_data;
        if (!reset) begin
            if (!idle) begin
                if (!op_pop_q) begin
                    we    = 1'b1;
                    waddr = sp_m1;
                    wdata = lo_q;
                end
            end else if (two_push) begin
                we    = 1'b1;
                waddr = sp_q;
                wdata = hi_w;
            end else if (bus.mem_write && wsrc00 && !exc_c
                         && bus.memory_address_select != 2'b11) begin
                we = 1'b1;
            end
        end
    end

    // Memory array: contents survive reset
    always_ff @(posedge clk) begin
        if (we)
            mem_q[waddr] <= wdata;
    end

    // Stack FSM, SP and the MEM/WB register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sp_q     <= SP_RESET;
            lo_q     <= '0;
            op_pop_q <= 1'b0;
            kind_q   <= 1'b0;
            mdo_q    <= '0;
            alu_q    <= '0;
            rw_q     <= 1'b0;
            wb_q     <= '0;
            pc_q     <= '0;
            pcl_q    <= 1'b0;
            cond_q   <= '0;
            fll_q    <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            pcl_q <= 1'b0;
            fll_q <= 1'b0;
            exc_q <= 1'b0;
            if (stall_c) begin
                rw_q <= 1'b0;
            end else begin
                alu_q <= bus.alu_result;
                wb_q  <= bus.wb_sel;
                rw_q  <= bus.reg_write & ~exc_c;
            end
            unique case (state_q)
                IDLE: begin
                    if (exc_c) begin
                        exc_q <= 1'b1;
                    end else if (two_push) begin
                        state_q  <= SECOND;
                        op_pop_q <= 1'b0;
                        lo_q     <= bus.PC[15:0];
                    end else if (two_pop) begin
                        state_q  <= SECOND;
                        op_pop_q <= 1'b1;
                        kind_q   <= bus.memory_write_src_select[1];
                        lo_q     <= mem_q[sp_p1];
                    end else begin
                        if (rd_en)
                            mdo_q <= mem_q[addr];
                        if (one_push)
                            sp_q <= sp_m1;
                        else if (one_pop)
                            sp_q <= sp_p1;
                    end
                end
                SECOND: begin
                    state_q <= IDLE;
                    if (op_pop_q) begin
                        sp_q  <= sp_p2;
                        pcl_q <= 1'b1;
                        if (kind_q) begin
                            pc_q   <= {3'b000, pop_hi[12:0], lo_q};
                            cond_q <= pop_hi[15:13];
                            fll_q  <= 1'b1;
                        end else begin
                            pc_q <= {pop_hi, lo_q};
                        end
                    end else begin
                        sp_q <= sp_m2;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_data_out               = mdo_q;
    assign bus.alu_result_out             = alu_q;
    assign bus.reg_write_out              = rw_q;
    assign bus.wb_sel_out                 = wb_q;
    assign bus.stall                      = stall_c;
    assign bus.pc_from_mem                = pc_q;
    assign bus.pc_load                    = pcl_q;
    assign bus.conditions_from_memory_pop = cond_q;
    assign bus.flags_load                 = fll_q;
    assign bus.empty_stack_exception      = exc_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: operation-level model of memory and stack,
// random and directed operations, checked every cycle.
module tb_memory_stage;
    localparam int OP_NOP  = 0;
    localparam int OP_ST   = 1;
    localparam int OP_LD   = 2;
    localparam int OP_STLD = 3;
    localparam int OP_PUSH = 4;
    localparam int OP_POP  = 5;
    localparam int OP_CALL = 6;
    localparam int OP_INT  = 7;
    localparam int OP_RET  = 8;
    localparam int OP_RTI  = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;

    memory_stage_if bus();

    memory_stage dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [15:0] mem_m [4096];
    int          sp_m = 4095;

    logic        exp_stall = 1'b0;
    logic [15:0] exp_mdo = '0;
    logic [15:0] exp_alu = '0;
    logic        exp_rw = 1'b0;
    logic [1:0]  exp_wb = '0;
    logic [31:0] exp_pc = '0;
    logic        exp_pcl = 1'b0;
    logic [2:0]  exp_cond = '0;
    logic        exp_fll = 1'b0;
    logic        exp_exc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(bus.stall), 32'(exp_stall));
            chk("mem_data_out", 32'(bus.mem_data_out), 32'(exp_mdo));
            chk("alu_result_out", 32'(bus.alu_result_out), 32'(exp_alu));
            chk("reg_write_out", 32'(bus.reg_write_out), 32'(exp_rw));
            chk("wb_sel_out", 32'(bus.wb_sel_out), 32'(exp_wb));
            chk("pc_from_mem", bus.pc_from_mem, exp_pc);
            chk("pc_load", 32'(bus.pc_load), 32'(exp_pcl));
            chk("cond_pop", 32'(bus.conditions_from_memory_pop),
                32'(exp_cond));
            chk("flags_load", 32'(bus.flags_load), 32'(exp_fll));
            chk("empty_exc", 32'(bus.empty_stack_exception),
                32'(exp_exc));
            chk("sp", 32'(dut.sp_q), 32'(sp_m));
        end
    end

    task automatic clear_exp();
        exp_stall = 1'b0;
        exp_mdo = '0;
        exp_alu = '0;
        exp_rw = 1'b0;
        exp_wb = '0;
        exp_pc = '0;
        exp_pcl = 1'b0;
        exp_cond = '0;
        exp_fll = 1'b0;
        exp_exc = 1'b0;
        sp_m = 4095;
    endtask

    task automatic clear_pulses();
        exp_pcl = 1'b0;
        exp_fll = 1'b0;
        exp_exc = 1'b0;
    endtask

    task automatic drive(input int k, input logic [15:0] alu,
                         input logic [15:0] d, input logic [31:0] pc,
                         input logic [2:0] fl, input logic rw,
                         input logic [1:0] wbs);
        bit pushk, popk;
        pushk = (k == OP_PUSH) || (k == OP_CALL) || (k == OP_INT);
        popk  = (k == OP_POP) || (k == OP_RET) || (k == OP_RTI);
        bus.mem_read  = popk || (k == OP_LD) || (k == OP_STLD);
        bus.mem_write = pushk || (k == OP_ST) || (k == OP_STLD);
        bus.mem_push  = pushk;
        bus.mem_pop   = popk;
        bus.memory_address_select = pushk ? 2'b01 : popk ? 2'b10 : 2'b00;
        if (k == OP_CALL || k == OP_RET)
            bus.memory_write_src_select = 2'b01;
        else if (k == OP_INT || k == OP_RTI)
            bus.memory_write_src_select = 2'b10;
        else
            bus.memory_write_src_select = 2'b00;
        bus.alu_result = alu;
        bus.store_data = d;
        bus.PC         = pc;
        bus.flags      = fl;
        bus.reg_write  = rw;
        bus.wb_sel     = wbs;
    endtask

    task automatic op(input int k, input logic [15:0] alu,
                      input logic [15:0] d, input logic [31:0] pc,
                      input logic [2:0] fl, input logic rw,
                      input logic [1:0] wbs);
        bit two, isp, emp;
        int a, s1, s2, sm1;
        logic [15:0] hi, lo;
        drive(k, alu, d, pc, fl, rw, wbs);
        two = (k >= OP_CALL);
        isp = (k == OP_POP) || (k == OP_RET) || (k == OP_RTI);
        emp = isp && (sp_m == 4095 || (two && sp_m == 4094));
        a   = int'(alu[11:0]);
        s1  = (sp_m + 1) % 4096;
        s2  = (sp_m + 2) % 4096;
        sm1 = (sp_m + 4095) % 4096;
        if (emp || !two) begin
            exp_stall = 1'b0;
            @(posedge clk);
            #2;
            clear_pulses();
            exp_alu = alu;
            exp_wb  = wbs;
            exp_rw  = rw & ~emp;
            if (emp) begin
                exp_exc = 1'b1;
            end else begin
                case (k)
                    OP_LD:   exp_mdo = mem_m[a];
                    OP_ST:   mem_m[a] = d;
                    OP_STLD: begin
                        exp_mdo = mem_m[a];
                        mem_m[a] = d;
                    end
                    OP_PUSH: begin
                        mem_m[sp_m] = d;
                        sp_m = sm1;
                    end
                    OP_POP: begin
                        exp_mdo = mem_m[s1];
                        sp_m = s1;
                    end
                    default: ;
                endcase
            end
        end else begin
            exp_stall = 1'b1;
            @(posedge clk);
            #2;
            clear_pulses();
            exp_rw = 1'b0;
            if (!isp)
                mem_m[sp_m] = (k == OP_CALL) ? pc[31:16]
                                             : {fl, pc[28:16]};
            exp_stall = 1'b0;
            @(posedge clk);
            #2;
            clear_pulses();
            exp_alu = alu;
            exp_wb  = wbs;
            exp_rw  = rw;
            if (!isp) begin
                mem_m[sm1] = pc[15:0];
                sp_m = (sp_m + 4094) % 4096;
            end else begin
                lo = mem_m[s1];
                hi = mem_m[s2];
                exp_pcl = 1'b1;
                if (k == OP_RET) begin
                    exp_pc = {hi, lo};
                end else begin
                    exp_pc   = {3'b000, hi[12:0], lo};
                    exp_cond = hi[15:13];
                    exp_fll  = 1'b1;
                end
                sp_m = s2;
            end
        end
    endtask

    task automatic op0(input int k, input logic [15:0] alu,
                       input logic [15:0] d);
        op(k, alu, d, 32'h0, 3'b000, 1'b1, 2'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] save;
        int k;
        logic [15:0] alu;
        drive(OP_NOP, 16'h0, 16'h0, 32'h0, 3'b000, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mdo", 32'(bus.mem_data_out), 32'h0);
        chk("rst_alu", 32'(bus.alu_result_out), 32'h0);
        chk("rst_pc", bus.pc_from_mem, 32'h0);
        chk("rst_sp", 32'(dut.sp_q), 32'd4095);
        reset = 1'b0;
        clear_exp();
        chk_en = 1'b1;

        for (int i = 0; i < 4096; i++)
            op0(OP_PUSH, 16'(i), 16'(i * 7 + 3));
        chk("wrap_sp", 32'(dut.sp_q), 32'd4095);
        chk("wrap_exc", 32'(bus.empty_stack_exception), 32'h0);
        chk("wrap_m0", 32'(dut.mem_q[0]), 32'(16'(4095 * 7 + 3)));

        chk_en = 1'b0;
        drive(OP_CALL, 16'h0, 16'h0, 32'h0001_0020, 3'b000, 1'b1, 2'b01);
        #1;
        chk("t1_stall", 32'(bus.stall), 32'h1);
        @(posedge clk);
        #2;
        mem_m[4095] = 16'h0001;
        save = mem_m[4094];
        reset = 1'b1;
        #1;
        chk("t1_stall_rst", 32'(bus.stall), 32'h0);
        chk("t1_rw", 32'(bus.reg_write_out), 32'h0);
        chk("t1_alu", 32'(bus.alu_result_out), 32'h0);
        chk("t1_pcl", 32'(bus.pc_load), 32'h0);
        @(posedge clk);
        #2;
        drive(OP_NOP, 16'h0, 16'h0, 32'h0, 3'b000, 1'b0, 2'b00);
        reset = 1'b0;
        chk("t1_sp", 32'(dut.sp_q), 32'd4095);
        chk("t1_m4094", 32'(dut.mem_q[4094]), 32'(save));
        chk("t1_m4095", 32'(dut.mem_q[4095]), 32'h0001);
        clear_exp();
        chk_en = 1'b1;
        op0(OP_NOP, 16'h0, 16'h0);

        op0(OP_ST, 16'h0010, 16'hBEEF);
        op0(OP_LD, 16'h0010, 16'h0);
        chk("t2_load", 32'(bus.mem_data_out), 32'hBEEF);
        op0(OP_ST, 16'h0020, 16'h1111);
        op0(OP_STLD, 16'h0020, 16'h2222);
        chk("rbw_old", 32'(bus.mem_data_out), 32'h1111);
        op0(OP_LD, 16'h0020, 16'h0);
        chk("rbw_new", 32'(bus.mem_data_out), 32'h2222);

        op0(OP_PUSH, 16'h0, 16'h1234);
        chk("t3_sp_push", 32'(dut.sp_q), 32'd4094);
        op0(OP_POP, 16'h0, 16'h0);
        chk("t3_sp_pop", 32'(dut.sp_q), 32'd4095);
        chk("t3_data", 32'(bus.mem_data_out), 32'h1234);

        op(OP_CALL, 16'h0, 16'h0, 32'h0001_0020, 3'b000, 1'b1, 2'b00);
        chk("t4_m4095", 32'(dut.mem_q[4095]), 32'h0001);
        chk("t4_m4094", 32'(dut.mem_q[4094]), 32'h0020);
        chk("t4_sp", 32'(dut.sp_q), 32'd4093);
        op(OP_RET, 16'h0, 16'h0, 32'h0, 3'b000, 1'b0, 2'b00);
        chk("t4_pcl", 32'(bus.pc_load), 32'h1);
        chk("t4_pc", bus.pc_from_mem, 32'h0001_0020);
        chk("t4_sp_ret", 32'(dut.sp_q), 32'd4095);
        op0(OP_NOP, 16'h0, 16'h0);
        chk("t4_pcl_pulse", 32'(bus.pc_load), 32'h0);

        op(OP_INT, 16'h0, 16'h0, 32'h0000_0040, 3'b101, 1'b0, 2'b00);
        chk("t5_hi", 32'(dut.mem_q[4095]), 32'hA000);
        op(OP_RTI, 16'h0, 16'h0, 32'h0, 3'b000, 1'b0, 2'b00);
        chk("t5_cond", 32'(bus.conditions_from_memory_pop), 32'h5);
        chk("t5_fll", 32'(bus.flags_load), 32'h1);
        chk("t5_pc", bus.pc_from_mem, 32'h0000_0040);

        op0(OP_POP, 16'h0, 16'h0);
        chk("t6_exc", 32'(bus.empty_stack_exception), 32'h1);
        chk("t6_sp", 32'(dut.sp_q), 32'd4095);
        chk("t6_rw", 32'(bus.reg_write_out), 32'h0);
        op0(OP_NOP, 16'h0, 16'h0);
        chk("t6_pulse", 32'(bus.empty_stack_exception), 32'h0);

        op0(OP_PUSH, 16'h0, 16'h5555);
        op(OP_RET, 16'h0, 16'h0, 32'h0, 3'b000, 1'b1, 2'b00);
        chk("ret_empty_exc", 32'(bus.empty_stack_exception), 32'h1);
        op0(OP_POP, 16'h0, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 9));
            alu = {4'($urandom), 4'h0, 8'($urandom)};
            op(k, alu, 16'($urandom), $urandom, 3'($urandom),
               1'($urandom), 2'($urandom));
        end
        op0(OP_NOP, 16'h0, 16'h0);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
